alu_mul_sequencer: RTL
======================

# alu_mul_sequencer

Multi-cycle unsigned shift-and-add multiplier controller.
- Borrows the shared ALU's ADD operation to compute the low word of a × b.
- Sequences one accumulate step per cycle and performs the shifts locally.
- Sits between the execute-stage issue logic (valid/ready request) and the ALU operand/result ports.
- Returns the product over a valid/ready response channel.

## Interface
Parameters:
- WORD_BITWIDTH, 32, operand/result width
- ADD_OP, 4'b0010, ALU opcode driven for accumulate steps
- IDLE_OP, 4'b0000, ALU opcode driven when not running (AND)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_a  in  WORD_BITWIDTH  multiplicand
- req_b  in  WORD_BITWIDTH  multiplier
- resp_valid  out  1  product available
- resp_ready  in  1  consumer accepts product
- resp_product  out  WORD_BITWIDTH  (a × b) mod 2^WORD_BITWIDTH
- busy  out  1  high in RUN or DONE
- alu_operation  out  4  opcode to the shared ALU
- alu_addend1  out  WORD_BITWIDTH  ALU operand 1
- alu_addend2  out  WORD_BITWIDTH  ALU operand 2
- alu_result  in  WORD_BITWIDTH  ALU combinational result

## Operation
- Internal registers:
  - mcand, mplier, acc: WORD_BITWIDTH each
  - step counter: $clog2(WORD_BITWIDTH) bits
  - state: IDLE, RUN, DONE
- IDLE:
  - req_ready=1.
  - On req_valid: mcand←req_a, mplier←req_b, acc←0, step←0, go to RUN.
- RUN:
  - alu_operation=ADD_OP, alu_addend1=acc, alu_addend2 = mplier[0] ? mcand : 0.
  - Each cycle: acc←alu_result, mcand←mcand<<1 (MSB discarded), mplier←mplier>>1 (zero fill), step←step+1.
  - Leaves for DONE after the step where step==WORD_BITWIDTH-1; see Configuration for early exit.
- DONE:
  - resp_valid=1, resp_product=acc, held stable until resp_ready.
  - On resp_valid&&resp_ready, go to IDLE.
- Outside RUN: alu_operation=IDLE_OP, alu_addend1=alu_addend2=0.
- Arithmetic:
  - Unsigned; overflow above WORD_BITWIDTH bits is silently dropped.
  - Equivalent to the low word of the full product.
- req_valid in RUN/DONE is ignored (req_ready=0); the request must be held by the sender.
- resp_product is valid only while resp_valid=1; it keeps the last acc value otherwise.

## Timing
- Reset (async assert, sync deassert by the system):
  - state=IDLE, acc/mcand/mplier/step=0.
  - Outputs: req_ready=1, resp_valid=0, resp_product=0, busy=0, alu_operation=IDLE_OP, alu_addends=0.
- Accept on edge E (req_valid&&req_ready). RUN occupies cycles E+1 … E+WORD_BITWIDTH.
- resp_valid rises after edge E+WORD_BITWIDTH. Full-length latency is WORD_BITWIDTH cycles from accept to resp_valid.
- Response handshake on edge H. IDLE, with req_ready=1, holds from H+1; next accept at earliest edge H+1.
- No same-cycle response/accept overlap. Minimum issue interval is WORD_BITWIDTH+2 cycles with resp_ready tied high.
- Reset mid-RUN or mid-DONE:
  - Immediate return to IDLE.
  - Pending operation is discarded; no response is produced.
- The ALU path is combinational: alu_result is sampled in the same cycle its operands are driven.

## Configuration
- MUL_EARLY_EXIT_EN defined:
  - RUN also exits to DONE after any step where the shifted multiplier (mplier>>1) is zero.
  - At least one RUN cycle always executes, including b=0.
  - Latency = max(1, index of highest set bit of b + 1) cycles.
- Not defined: always exactly WORD_BITWIDTH RUN cycles regardless of operands.
- resp_product is identical in both builds.

## Test plan
- a=3, b=5, resp_ready=1 → resp_product=15. resp_valid after 32 cycles (no macro) or 3 cycles (macro). busy high throughout.
- a=0xFFFFFFFF, b=2 → resp_product=0xFFFFFFFE. a=0x80000000, b=2 → 0x00000000 (overflow dropped).
- a=7, b=1, resp_ready=0 for 10 cycles after resp_valid:
  - resp_valid and resp_product=7 stay stable.
  - A second req_valid during this time is not accepted.
  - It is accepted on the cycle after the response handshake.
- rst_n pulsed low at RUN step 10 of a=9,b=9:
  - All outputs at reset values immediately.
  - No resp_valid afterwards.
  - A new request a=2,b=2 then yields 4.
- During RUN:
  - alu_operation=0010 every cycle.
  - alu_addend2 is 0 on cycles where the current mplier LSB is 0.
  - Outside RUN, alu_operation=0000 and addends=0.
- b=0 → product 0. One RUN cycle with macro, 32 without.

Source files
------------

// File: rtl/alu_mul_sequencer_if.sv
// alu_mul_sequencer_if
//   Bundles the request channel, the response channel and the shared-ALU
//   operand/result port of the multiplier sequencer.
//
//   Handshake semantics (both channels): a transfer happens on a rising clock
//   edge where valid && ready are both high. The sender raises valid and holds
//   it, together with its payload, unchanged until that edge. valid never
//   depends combinationally on ready. The response payload (resp_product) is
//   held stable for as long as resp_valid is high.
//
//   Modports:
//     slave  - the sequencer: takes requests, produces responses, drives the
//              ALU operands and reads the ALU result.
//     master - the environment: issue logic, response consumer and the ALU.
interface alu_mul_sequencer_if #(
    parameter int WORD_BITWIDTH = 32
);
    logic                     req_valid;
    logic                     req_ready;
    logic [WORD_BITWIDTH-1:0] req_a;
    logic [WORD_BITWIDTH-1:0] req_b;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [WORD_BITWIDTH-1:0] resp_product;
    logic [3:0]               alu_operation;
    logic [WORD_BITWIDTH-1:0] alu_addend1;
    logic [WORD_BITWIDTH-1:0] alu_addend2;
    logic [WORD_BITWIDTH-1:0] alu_result;

    modport slave (
        input  req_valid, req_a, req_b, resp_ready, alu_result,
        output req_ready, resp_valid, resp_product,
               alu_operation, alu_addend1, alu_addend2
    );

    modport master (
        output req_valid, req_a, req_b, resp_ready, alu_result,
        input  req_ready, resp_valid, resp_product,
               alu_operation, alu_addend1, alu_addend2
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
//   Multi-cycle unsigned shift-and-add multiplier controller. Produces the low
//   word of a * b by borrowing the shared ALU's ADD operation for one
//   accumulate step per cycle; the multiplicand/multiplier shifts are local.
//
//   Ports:
//     clk        - clock, all state updates on the rising edge
//     rst_n      - asynchronous active-low reset
//     bus        - alu_mul_sequencer_if.slave: req_* request channel,
//                  resp_* response channel, alu_* shared-ALU port
//     busy       - high in RUN or DONE
//     state_dbg  - current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
//   Optional feature macro: MUL_EARLY_EXIT_EN
//     When defined, RUN ends as soon as the remaining (shifted) multiplier is
//     zero, so latency follows the highest set bit of b (minimum one cycle).
//     When undefined, RUN always lasts WORD_BITWIDTH cycles. The product is
//     identical in both builds.
module alu_mul_sequencer #(
    parameter int       WORD_BITWIDTH = 32,
    parameter bit [3:0] ADD_OP        = 4'b0010,
    parameter bit [3:0] IDLE_OP       = 4'b0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    alu_mul_sequencer_if.slave         bus,
    output logic                       busy,
    output logic [1:0]                 state_dbg
);

    localparam int STEP_W = (WORD_BITWIDTH > 1) ? $clog2(WORD_BITWIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [WORD_BITWIDTH-1:0] mcand_q, mcand_d;
    logic [WORD_BITWIDTH-1:0] mplier_q, mplier_d;
    logic [WORD_BITWIDTH-1:0] acc_q, acc_d;
    logic [STEP_W-1:0]        step_q, step_d;
    logic                     run_exit;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            step_q   <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            step_q   <= step_d;
        end
    end

    // RUN ends after the last bit position; with early exit it also ends once
    // no set multiplier bits remain after this step's shift.
    always_comb begin
        run_exit = (step_q == STEP_W'(WORD_BITWIDTH - 1));
`ifdef MUL_EARLY_EXIT_EN
        if ((mplier_q >> 1) == '0) begin
            run_exit = 1'b1;
        end
`endif
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        step_d   = step_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    mcand_d  = bus.req_a;
                    mplier_d = bus.req_b;
                    acc_d    = '0;
                    step_d   = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // The ALU is combinational: its result for this cycle's
                // operands is captured on the same edge.
                acc_d    = bus.alu_result;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                step_d   = step_q + 1'b1;
                if (run_exit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        bus.req_ready     = (state_q == IDLE);
        bus.resp_valid    = (state_q == DONE);
        bus.resp_product  = acc_q;
        busy              = (state_q != IDLE);
        state_dbg         = state_q;
        bus.alu_operation = IDLE_OP;
        bus.alu_addend1   = '0;
        bus.alu_addend2   = '0;
        if (state_q == RUN) begin
            bus.alu_operation = ADD_OP;
            bus.alu_addend1   = acc_q;
            bus.alu_addend2   = mplier_q[0] ? mcand_q : '0;
        end
    end

endmodule
